// File: rtl/mem_access_stage_if.sv
// Data-memory port of the memory-access stage.
// The stage drives a request (address, write enable, byte strobes, write data)
// and the memory answers with a one-cycle ack carrying the read word.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Stage side: issues requests, consumes ack/read data
  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wstrb,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  // Memory side: serves requests
  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage.
// Loads and stores run one req/ack transaction on the data-memory port; load
// data is lane-selected and sign/zero-extended. Every other alucode passes
// alu_result through with one cycle of latency. Results leave through a
// valid/ready handshake; misaligned accesses and memory timeouts are reported
// as flags travelling with the result.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                alucode,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               store_data,
  input  logic [4:0]                rd_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_data,
  output logic [4:0]                out_rd,
  output logic                      misaligned,
  output logic                      bus_err,
  mem_access_stage_if.master        mem
);

  // Memory alucodes, define.vh encoding
  localparam logic [5:0] ALU_LB  = 6'd9;
  localparam logic [5:0] ALU_LH  = 6'd10;
  localparam logic [5:0] ALU_LW  = 6'd11;
  localparam logic [5:0] ALU_LBU = 6'd12;
  localparam logic [5:0] ALU_LHU = 6'd13;
  localparam logic [5:0] ALU_SB  = 6'd14;
  localparam logic [5:0] ALU_SH  = 6'd15;
  localparam logic [5:0] ALU_SW  = 6'd16;

  // The counter only needs to reach TIMEOUT_CYCLES-1: the edge that would
  // make it TIMEOUT_CYCLES is the timeout edge itself.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state_reg, state_next;

  logic [5:0]       op_reg,        op_next;
  logic [1:0]       addr_lo_reg,   addr_lo_next;
  logic             out_valid_reg, out_valid_next;
  logic [31:0]      out_data_reg,  out_data_next;
  logic [4:0]       out_rd_reg,    out_rd_next;
  logic             mis_reg,       mis_next;
  logic             berr_reg,      berr_next;
  logic             mem_req_reg,   mem_req_next;
  logic             mem_we_reg,    mem_we_next;
  logic [31:0]      mem_addr_reg,  mem_addr_next;
  logic [3:0]       mem_wstrb_reg, mem_wstrb_next;
  logic [31:0]      mem_wdata_reg, mem_wdata_next;
  logic [CNT_W-1:0] tmo_cnt_reg,   tmo_cnt_next;

  logic        accept;
  logic        in_is_mem;
  logic        in_is_store;
  logic        in_misaligned;
  logic [3:0]  in_wstrb;
  logic [31:0] in_wdata;
  logic [31:0] load_value;

  logic [7:0]  rd_byte [4];
  logic [15:0] rd_half [2];

  assign in_ready = (state_reg == IDLE) || ((state_reg == RESP) && out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_rd     = out_rd_reg;
  assign misaligned = mis_reg;
  assign bus_err    = berr_reg;

  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wstrb = mem_wstrb_reg;
  assign mem.mem_wdata = mem_wdata_reg;

  // Split the read word into its byte and halfword lanes
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
    assign rd_byte[gi] = mem.mem_rdata[8*gi +: 8];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
    assign rd_half[gi] = mem.mem_rdata[16*gi +: 16];
  end

  // Decode the incoming op: class, alignment and store lane encoding
  always_comb begin
    in_is_mem     = 1'b0;
    in_is_store   = 1'b0;
    in_misaligned = 1'b0;
    in_wstrb      = 4'b0000;
    in_wdata      = 32'd0;
    case (alucode)
      ALU_LB, ALU_LBU: begin
        in_is_mem = 1'b1;
      end
      ALU_LH, ALU_LHU: begin
        in_is_mem     = 1'b1;
        in_misaligned = alu_result[0];
      end
      ALU_LW: begin
        in_is_mem     = 1'b1;
        in_misaligned = (alu_result[1:0] != 2'b00);
      end
      ALU_SB: begin
        in_is_mem   = 1'b1;
        in_is_store = 1'b1;
        in_wstrb    = 4'b0001 << alu_result[1:0];
        in_wdata    = {4{store_data[7:0]}};
      end
      ALU_SH: begin
        in_is_mem     = 1'b1;
        in_is_store   = 1'b1;
        in_misaligned = alu_result[0];
        in_wstrb      = alu_result[1] ? 4'b1100 : 4'b0011;
        in_wdata      = {2{store_data[15:0]}};
      end
      ALU_SW: begin
        in_is_mem     = 1'b1;
        in_is_store   = 1'b1;
        in_misaligned = (alu_result[1:0] != 2'b00);
        in_wstrb      = 4'b1111;
        in_wdata      = store_data;
      end
      default: ;
    endcase
  end

  // Lane-select and extend the returned word for the latched load op
  always_comb begin
    load_value = mem.mem_rdata;
    case (op_reg)
      ALU_LB:  load_value = {{24{rd_byte[addr_lo_reg][7]}}, rd_byte[addr_lo_reg]};
      ALU_LBU: load_value = {24'd0, rd_byte[addr_lo_reg]};
      ALU_LH:  load_value = {{16{rd_half[addr_lo_reg[1]][15]}}, rd_half[addr_lo_reg[1]]};
      ALU_LHU: load_value = {16'd0, rd_half[addr_lo_reg[1]]};
      ALU_LW:  load_value = mem.mem_rdata;
      default: load_value = 32'd0;
    endcase
  end

  // Next-state and next-output logic; a new accept overrides the state's own update
  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    addr_lo_next   = addr_lo_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_rd_next    = out_rd_reg;
    mis_next       = mis_reg;
    berr_next      = berr_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wstrb_next = mem_wstrb_reg;
    mem_wdata_next = mem_wdata_reg;
    tmo_cnt_next   = tmo_cnt_reg;

    case (state_reg)
      REQ: begin
        if (mem.mem_ack) begin
          // Ack wins even on the edge where the timeout would fire
          state_next     = RESP;
          mem_req_next   = 1'b0;
          out_valid_next = 1'b1;
          mis_next       = 1'b0;
          berr_next      = 1'b0;
          out_data_next  = mem_we_reg ? 32'd0 : load_value;
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_reg == CNT_LAST)) begin
          state_next     = RESP;
          mem_req_next   = 1'b0;
          out_valid_next = 1'b1;
          mis_next       = 1'b0;
          berr_next      = 1'b1;
          out_data_next  = 32'd0;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
          mis_next       = 1'b0;
          berr_next      = 1'b0;
        end
      end
      default: ;
    endcase

    if (accept) begin
      op_next      = alucode;
      addr_lo_next = alu_result[1:0];
      out_rd_next  = rd_addr;
      mis_next     = 1'b0;
      berr_next    = 1'b0;
      if (!in_is_mem) begin
        state_next     = RESP;
        out_valid_next = 1'b1;
        out_data_next  = alu_result;
      end else if (in_misaligned) begin
        state_next     = RESP;
        out_valid_next = 1'b1;
        out_data_next  = 32'd0;
        mis_next       = 1'b1;
      end else begin
        state_next     = REQ;
        out_valid_next = 1'b0;
        out_data_next  = 32'd0;
        mem_req_next   = 1'b1;
        mem_we_next    = in_is_store;
        mem_addr_next  = {alu_result[31:2], 2'b00};
        mem_wstrb_next = in_wstrb;
        mem_wdata_next = in_wdata;
        tmo_cnt_next   = '0;
      end
    end
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Result, bus and timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg        <= 6'd0;
      addr_lo_reg   <= 2'd0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 32'd0;
      out_rd_reg    <= 5'd0;
      mis_reg       <= 1'b0;
      berr_reg      <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wstrb_reg <= 4'd0;
      mem_wdata_reg <= 32'd0;
      tmo_cnt_reg   <= '0;
    end else begin
      op_reg        <= op_next;
      addr_lo_reg   <= addr_lo_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_rd_reg    <= out_rd_next;
      mis_reg       <= mis_next;
      berr_reg      <= berr_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wstrb_reg <= mem_wstrb_next;
      mem_wdata_reg <= mem_wdata_next;
      tmo_cnt_reg   <= tmo_cnt_next;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized ops checked
// against a transaction-level model of the stage and a byte-lane memory.
module tb_mem_access_stage;

  localparam int TMO = 4;

  localparam logic [5:0] ALU_LB  = 6'd9;
  localparam logic [5:0] ALU_LH  = 6'd10;
  localparam logic [5:0] ALU_LW  = 6'd11;
  localparam logic [5:0] ALU_LBU = 6'd12;
  localparam logic [5:0] ALU_LHU = 6'd13;
  localparam logic [5:0] ALU_SB  = 6'd14;
  localparam logic [5:0] ALU_SH  = 6'd15;
  localparam logic [5:0] ALU_SW  = 6'd16;
  localparam logic [5:0] ALU_ADD = 6'd17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  alucode = 6'd0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        misaligned;
  logic        bus_err;

  mem_access_stage_if mem_bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucode    (alucode),
    .alu_result (alu_result),
    .store_data (store_data),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model and responder controls
  logic [31:0] words [256];
  int          ack_lat   = 0;   // ack on this request cycle; 0 = never
  int          req_total = 0;   // request cycles seen for the current op
  bit          force_ack = 1'b0;
  logic [31:0] exp_addr  = 32'd0;
  logic        exp_we    = 1'b0;
  logic [3:0]  exp_wstrb = 4'd0;
  logic [31:0] exp_wdata = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int op_size(input logic [5:0] c);
    if (c == ALU_LB || c == ALU_LBU || c == ALU_SB) return 1;
    if (c == ALU_LH || c == ALU_LHU || c == ALU_SH) return 2;
    if (c == ALU_LW || c == ALU_SW) return 4;
    return 0;
  endfunction

  function automatic bit op_store(input logic [5:0] c);
    return (c == ALU_SB || c == ALU_SH || c == ALU_SW);
  endfunction

  function automatic bit op_signed(input logic [5:0] c);
    return (c == ALU_LB || c == ALU_LH);
  endfunction

  // Value of a load of 'size' bytes at byte offset 'off' in word w
  function automatic logic [31:0] load_model(input logic [31:0] w, input int off,
                                             input int size, input bit sgn);
    longint unsigned v, span;
    span = 64'd1 << (8 * size);
    v = {32'd0, w};
    v = (v >> (8 * off)) % span;
    if (sgn && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // Memory responder: acks on request cycle ack_lat, checks the held bus, applies stores
  initial begin
    int req_cycles;
    bit ack_now;
    req_cycles = 0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_req === 1'b1) begin
        req_cycles++;
        req_total++;
        check("mem_addr",  mem_bus.mem_addr,  exp_addr);
        check("mem_we",    32'(mem_bus.mem_we), 32'(exp_we));
        check("mem_wstrb", 32'(mem_bus.mem_wstrb), 32'(exp_wstrb));
        check("mem_wdata", mem_bus.mem_wdata, exp_wdata);
        ack_now = (ack_lat != 0) && (req_cycles == ack_lat);
        mem_bus.mem_rdata = words[mem_bus.mem_addr[9:2]];
        if (ack_now && mem_bus.mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_bus.mem_wstrb[b]) words[mem_bus.mem_addr[9:2]][8*b +: 8] = mem_bus.mem_wdata[8*b +: 8];
        end
        mem_bus.mem_ack = ack_now || force_ack;
      end else begin
        req_cycles = 0;
        mem_bus.mem_ack = force_ack;
      end
    end
  end

  // One op through the stage with out_ready low, then hold, then retire
  task automatic run_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd, input int lat, input int hold);
    int size, off, n, exp_cycles;
    bit st, mis, berr;
    logic [31:0] exp_data, held;
    size = op_size(code);
    st   = op_store(code);
    off  = int'(a % 4);
    mis  = (size != 0) && ((a % size) != 0);
    berr = (size != 0) && !mis && (lat == 0 || lat > TMO);
    if (size == 0 || mis) exp_cycles = 0;
    else if (berr) exp_cycles = TMO;
    else exp_cycles = lat;
    if (size == 0) exp_data = a;
    else if (mis || berr || st) exp_data = 32'd0;
    else exp_data = load_model(words[a[9:2]], off, size, op_signed(code));

    exp_addr  = a & ~32'd3;
    exp_we    = st;
    exp_wstrb = st ? 4'(((1 << size) - 1) << off) : 4'd0;
    exp_wdata = 32'd0;
    if (st) for (int i = 0; i < 4; i++) exp_wdata[8*i +: 8] = 8'(sd >> (8 * (i % size)));
    ack_lat   = lat;
    req_total = 0;

    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alucode = code; alu_result = a; store_data = sd; rd_addr = rd;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency",    32'(n), 32'(exp_cycles));
    check("out_data",   out_data, exp_data);
    check("out_rd",     32'(out_rd), 32'(rd));
    check("misaligned", 32'(misaligned), 32'(mis));
    check("bus_err",    32'(bus_err), 32'(berr));
    check("req_cycles", 32'(req_total), 32'(exp_cycles));
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data",  out_data, held);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("retire_valid", 32'(out_valid), 32'd0);
    check("retire_flags", 32'({misaligned, bus_err}), 32'd0);
    $display("op %0d addr %h sd %h rd %0d lat %0d -> data %h mis %0d berr %0d",
             code, a, sd, rd, lat, exp_data, mis, berr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  code;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) words[i] = $urandom;
    words[32'h100 >> 2] = 32'h80F1_7F02;

    // Reset values
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_out_rd",    32'(out_rd), 32'd0);
    check("rst_flags",     32'({misaligned, bus_err}), 32'd0);
    check("rst_mem_req",   32'(mem_bus.mem_req), 32'd0);
    check("rst_mem_we",    32'(mem_bus.mem_we), 32'd0);
    check("rst_mem_addr",  mem_bus.mem_addr, 32'd0);
    check("rst_mem_wstrb", 32'(mem_bus.mem_wstrb), 32'd0);
    check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through and loads/stores from the directed list
    run_op(ALU_ADD, 32'h0000_1234, 32'd0, 5'd5, 2, 0);
    run_op(ALU_LB,  32'h103, 32'd0, 5'd1, 2, 0);
    run_op(ALU_LBU, 32'h103, 32'd0, 5'd2, 2, 0);
    run_op(ALU_LH,  32'h102, 32'd0, 5'd3, 2, 0);
    run_op(ALU_LHU, 32'h100, 32'd0, 5'd4, 2, 0);
    run_op(ALU_LW,  32'h100, 32'd0, 5'd6, 2, 5);
    run_op(ALU_SB,  32'h201, 32'hAABB_CCDD, 5'd7, 2, 0);
    run_op(ALU_SH,  32'h202, 32'hAABB_CCDD, 5'd8, 1, 0);
    run_op(ALU_SW,  32'h200, 32'hAABB_CCDD, 5'd9, 3, 0);
    run_op(ALU_LW,  32'h200, 32'd0, 5'd10, 1, 0);
    run_op(ALU_LW,  32'h102, 32'd0, 5'd11, 2, 0);
    run_op(ALU_SH,  32'h201, 32'h1234_5678, 5'd12, 2, 0);
    run_op(ALU_LW,  32'h100, 32'd0, 5'd13, 0, 0);
    run_op(ALU_LW,  32'h100, 32'd0, 5'd14, TMO, 0);

    // Three back-to-back pass-through ops with out_ready held high
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_data",  out_data, 32'h100 + 32'(k - 1));
      end
      check("b2b_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; alucode = ALU_ADD; alu_result = 32'h100 + 32'(k); rd_addr = 5'(k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_data",  out_data, 32'h102);
    @(negedge clk);
    check("b2b_drain", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    $display("back-to-back: three pass-through results streamed");

    // Reset while a request is outstanding, then a stray ack
    ack_lat = 0;
    @(negedge clk);
    in_valid = 1'b1; alucode = ALU_LW; alu_result = 32'h100; rd_addr = 5'd3;
    exp_addr = 32'h100; exp_we = 1'b0; exp_wstrb = 4'd0; exp_wdata = 32'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("inflight_req", 32'(mem_bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_drops_req", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    force_ack = 1'b1;
    @(posedge clk);
    force_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_ack_valid", 32'(out_valid), 32'd0);
      check("late_ack_ready", 32'(in_ready), 32'd1);
    end
    $display("reset in REQ: request abandoned, late ack ignored");

    // Randomized ops
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) < 8) begin
        code = 6'(9 + $urandom_range(0, 7));
        a = 32'h100 + 32'($urandom_range(0, 32'h2FF));
      end else begin
        code = 6'($urandom_range(17, 63));
        a = $urandom;
      end
      run_op(code, a, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
